// File: rtl/lb_chan_fanout_if.sv
// Host local-bus plus per-channel target bus for lb_chan_fanout.
// master = host/channel environment, slave = the fanout block itself.
interface lb_chan_fanout_if #(
  parameter int N_CHAN = 2,
  parameter int AW     = 24,
  parameter int SUB_AW = 17,
  parameter int DW     = 32
);
  logic [AW-1:0]        lb_addr;
  logic [DW-1:0]        lb_data_out;
  logic                 lb_write;
  logic                 lb_rd;
  logic [DW-1:0]        lb_din;
  logic                 lb_rd_valid;
  logic                 busy;
  logic [SUB_AW-1:0]    ch_addr;
  logic [DW-1:0]        ch_data;
  logic [N_CHAN-1:0]    ch_write;
  logic [N_CHAN-1:0]    ch_read;
  logic [N_CHAN*DW-1:0] ch_din;
  logic [N_CHAN-1:0]    ch_rd_valid;
  logic [15:0]          timeout_count;
  logic [15:0]          overrun_count;

  modport master (
    output lb_addr, lb_data_out, lb_write, lb_rd, ch_din, ch_rd_valid,
    input  lb_din, lb_rd_valid, busy, ch_addr, ch_data, ch_write, ch_read,
           timeout_count, overrun_count
  );

  modport slave (
    input  lb_addr, lb_data_out, lb_write, lb_rd, ch_din, ch_rd_valid,
    output lb_din, lb_rd_valid, busy, ch_addr, ch_data, ch_write, ch_read,
           timeout_count, overrun_count
  );
endinterface

// File: rtl/lb_chan_fanout.sv
// Local-bus splitter: decodes a channel index from the upper address bits,
// fans strobes out one-hot, and tracks one outstanding read with a timeout.
module lb_chan_fanout #(
  parameter int              N_CHAN   = 2,
  parameter int              AW       = 24,
  parameter int              SUB_AW   = 17,
  parameter int              DW       = 32,
  parameter int              TIMEOUT  = 255,
  parameter logic [DW-1:0]   BAD_DATA = DW'(32'hdeadbeef)
) (
  input  logic           lb_clk,
  input  logic           rst,
  lb_chan_fanout_if.slave bus
);
  localparam int          CW         = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
  localparam logic [15:0] TIMER_LOAD = 16'(TIMEOUT);
  localparam logic [15:0] CNT_MAX    = 16'hffff;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        r_state;
  logic [15:0]       r_timer;
  logic              r_unmapped;
  logic [N_CHAN-1:0] r_sel_oh;
  logic [N_CHAN-1:0] r_ch_write;
  logic [N_CHAN-1:0] r_ch_read;
  logic [SUB_AW-1:0] r_ch_addr;
  logic [DW-1:0]     r_ch_data;
  logic [DW-1:0]     r_lb_din;
  logic              r_rd_valid;
  logic [15:0]       r_timeout_cnt;
  logic [15:0]       r_overrun_cnt;

  logic [CW-1:0]     w_idx;
  logic [N_CHAN-1:0] w_hit;
  logic              w_mapped;
  logic [DW-1:0]     w_masked [N_CHAN];
  logic [DW-1:0]     w_sel_data;
  logic              w_sel_valid;
  logic              w_rd_accept;
  logic              w_overrun;
  logic              w_unused;

  assign w_idx    = bus.lb_addr[SUB_AW +: CW];
  assign w_unused = ^bus.lb_addr;

  // Per-channel decode and read-data masking; an index >= N_CHAN hits nothing.
  for (genvar gi = 0; gi < N_CHAN; gi++) begin : g_chan
    assign w_hit[gi]    = (w_idx == CW'(gi));
    assign w_masked[gi] = {DW{r_sel_oh[gi]}} & bus.ch_din[gi*DW +: DW];
  end

  assign w_mapped = |w_hit;

  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < N_CHAN; k++) begin
      w_sel_data = w_sel_data | w_masked[k];
    end
  end

  assign w_sel_valid = |(bus.ch_rd_valid & r_sel_oh);

  // A read colliding with a write, or arriving while one is outstanding, is dropped.
  assign w_rd_accept = bus.lb_rd && !bus.lb_write && (r_state != S_WAIT);
  assign w_overrun   = bus.lb_rd && (bus.lb_write || (r_state == S_WAIT));

  always_ff @(posedge lb_clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_timer       <= '0;
      r_unmapped    <= 1'b0;
      r_sel_oh      <= '0;
      r_ch_write    <= '0;
      r_ch_read     <= '0;
      r_ch_addr     <= '0;
      r_ch_data     <= '0;
      r_lb_din      <= '0;
      r_rd_valid    <= 1'b0;
      r_timeout_cnt <= '0;
      r_overrun_cnt <= '0;
    end else begin
      r_ch_write <= '0;
      r_ch_read  <= '0;
      r_rd_valid <= 1'b0;

      if (bus.lb_write) begin
        r_ch_write <= w_hit;
        r_ch_addr  <= bus.lb_addr[SUB_AW-1:0];
        r_ch_data  <= bus.lb_data_out;
      end

      if (w_overrun && (r_overrun_cnt != CNT_MAX)) begin
        r_overrun_cnt <= r_overrun_cnt + 16'd1;
      end

      case (r_state)
        S_WAIT: begin
          // Unmapped reads spend one cycle here so their reply lands at t+2.
          if (r_unmapped || w_sel_valid || (r_timer == 16'd0)) begin
            r_state    <= S_DONE;
            r_rd_valid <= 1'b1;
            r_lb_din   <= w_sel_valid ? w_sel_data : BAD_DATA;
            if (!r_unmapped && !w_sel_valid && (r_timeout_cnt != CNT_MAX)) begin
              r_timeout_cnt <= r_timeout_cnt + 16'd1;
            end
          end else begin
            r_timer <= r_timer - 16'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          if (w_rd_accept) begin
            r_state    <= S_WAIT;
            r_sel_oh   <= w_hit;
            r_ch_read  <= w_hit;
            r_unmapped <= !w_mapped;
            r_timer    <= TIMER_LOAD;
          end
        end
      endcase
    end
  end

  assign bus.ch_write      = r_ch_write;
  assign bus.ch_read       = r_ch_read;
  assign bus.ch_addr       = r_ch_addr;
  assign bus.ch_data       = r_ch_data;
  assign bus.lb_din        = r_lb_din;
  assign bus.lb_rd_valid   = r_rd_valid;
  assign bus.busy          = (r_state == S_WAIT);
  assign bus.timeout_count = r_timeout_cnt;
  assign bus.overrun_count = r_overrun_cnt;
endmodule
